cdc_tx_pacer: RTL and testbench



---
 rtl/cdc_pkg.sv | 10 +
 rtl/cdc_tx_pacer_if.sv | 13 +
 rtl/cdc_tx_pacer_sync_fifo.sv | 46 ++++
 rtl/cdc_tx_pacer.sv | 49 ++++
 tb/tb_cdc_tx_pacer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and sizing helpers for the clka->clkb word-transfer path
package cdc_pkg;
  localparam int CDC_DW = 8;
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  function automatic int cnt_width(input int h, input int l);
    int m;
    m = h > l ? h : l;
    return m > 2 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/cdc_tx_pacer_if.sv
// cdc_tx_pacer_if: upstream valid/ready stream plus the paced synchroniser-facing outputs
interface cdc_tx_pacer_if #(parameter int DW = 8, parameter int DEPTH = 4);
  localparam int LW = $clog2(DEPTH + 1);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dataa;
  logic          new_dataa;
  logic [LW-1:0] level;
  logic          busy;
  modport master (output in_data, in_valid, input in_ready, dataa, new_dataa, level, busy);
  modport slave  (input in_data, in_valid, output in_ready, dataa, new_dataa, level, busy);
endinterface

// File: rtl/cdc_tx_pacer_sync_fifo.sv
// sync_fifo: power-of-two word FIFO with combinational head read and occupancy count
module sync_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic wr, rd;
  assign full  = lvl_q == LW'(DEPTH);
  assign empty = lvl_q == '0;
  assign level = lvl_q;
  assign rdata = mem_q[rp_q];
  // a full FIFO refuses writes even when a pop frees a slot this cycle
  always_comb begin
    wr    = push && !full;
    rd    = pop && !empty;
    wp_d  = wr ? wp_q + 1'b1 : wp_q;
    rp_d  = rd ? rp_q + 1'b1 : rp_q;
    lvl_d = lvl_q + LW'(wr) - LW'(rd);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      lvl_q <= lvl_d;
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= wdata;
endmodule

// File: rtl/cdc_tx_pacer.sv
// cdc_tx_pacer: buffers a byte stream and re-emits each word with a stretched, gapped strobe
module cdc_tx_pacer import cdc_pkg::*; #(
  parameter int DW = CDC_DW,
  parameter int DEPTH = 4,
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES = 4
) (
  input logic clka,
  input logic rsta,
  cdc_tx_pacer_if.slave bus
);
  localparam int CW = cnt_width(HIGH_CYCLES, LOW_CYCLES);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dataa_q, dataa_d, head;
  logic          new_q, new_d;
  logic          load, hold_end, gap_end, full, empty;
  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk(clka), .rst(rsta), .push(bus.in_valid), .pop(load), .wdata(bus.in_data),
    .rdata(head), .full(full), .empty(empty), .level(bus.level)
  );
  // a word is loaded from IDLE or straight from an expired GAP for back-to-back pacing
  always_comb begin
    hold_end = state_q == HOLD && cnt_q == '0;
    gap_end  = state_q == GAP && cnt_q == '0;
    load     = !empty && (state_q == IDLE || gap_end);
    state_d  = load ? HOLD : hold_end ? GAP : gap_end ? IDLE : state_q;
    cnt_d    = load ? CW'(HIGH_CYCLES - 1) : hold_end ? CW'(LOW_CYCLES - 1) :
               cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
    dataa_d  = load ? head : dataa_q;
    new_d    = load || (new_q && !hold_end);
  end
  always_ff @(posedge clka or posedge rsta)
    if (rsta) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dataa_q <= '0;
      new_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dataa_q <= dataa_d;
      new_q   <= new_d;
    end
  assign bus.in_ready  = !full;
  assign bus.dataa     = dataa_q;
  assign bus.new_dataa = new_q;
  assign bus.busy      = state_q != IDLE || !empty;
endmodule

// File: tb/tb_cdc_tx_pacer.sv
// tb_cdc_tx_pacer: directed vector and sequence checks for the paced CDC source stage
module tb_cdc_tx_pacer;
  localparam int DW = 8, DEPTH = 4, H = 4, L = 4;
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e_new;
    logic [7:0] e_dataa;
    logic       e_rdy;
    logic [2:0] e_lvl;
    logic       e_busy;
  } vec_t;
  logic clka = 0, clkb = 0, rsta = 1;
  cdc_tx_pacer_if #(.DW(DW), .DEPTH(DEPTH)) bus();
  cdc_tx_pacer #(.DW(DW), .DEPTH(DEPTH), .HIGH_CYCLES(H), .LOW_CYCLES(L)) dut (
    .clka(clka), .rsta(rsta), .bus(bus)
  );
  always #5 clka = ~clka;
  initial begin
    #3;
    forever #10 clkb = ~clkb;
  end
  int total = 0, bad = 0, cyc = 0, hi_run = 0, lo_run = 0, rcv = 0, n = 0, sent = 0;
  logic prev_new = 0;
  bit run_en = 0, sb_en = 0, seen_fall = 0, fire = 0, e2e_en = 0;
  int rise_cyc[$];
  logic [7:0] rise_dat[$], exp_q[$], b_got[$];
  vec_t vt[11];
  int acc[6];
  int exp_acc[6] = '{0, 1, 2, 3, 4, 10};
  logic s1 = 0, s2 = 0, s3 = 0;
  // clkb-side reference synchroniser: 2-flop level sync, rising-edge detect, capture dataa
  always @(posedge clkb) begin
    s1 <= bus.new_dataa;
    s2 <= s1;
    s3 <= s2;
    if (s2 && !s3 && e2e_en) b_got.push_back(bus.dataa);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clka);
    cyc++;
    #1;
    if (bus.new_dataa && !prev_new) begin
      rise_cyc.push_back(cyc);
      rise_dat.push_back(bus.dataa);
      if (run_en && seen_fall) chk("low_run_min", 32'(lo_run >= L), 1);
      if (sb_en) begin
        rcv++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra got=%0h want=none", bus.dataa);
        end else chk("sb_data", bus.dataa, exp_q.pop_front());
      end
    end
    if (!bus.new_dataa && prev_new) begin
      if (run_en) chk("high_run", hi_run, H);
      seen_fall = 1;
    end
    hi_run = bus.new_dataa ? (prev_new ? hi_run + 1 : 1) : 0;
    lo_run = !bus.new_dataa ? (!prev_new ? lo_run + 1 : 1) : 0;
    prev_new = bus.new_dataa;
  endtask
  task automatic send(input logic [7:0] w);
    bus.in_valid = 1;
    bus.in_data = w;
    n = 0;
    do begin
      fire = bus.in_ready;
      step();
      n++;
    end while (!fire && n < 50);
    if (!fire) chk("send_timeout", 0, 1);
    bus.in_valid = 0;
  endtask
  task automatic drain(input string nm);
    n = 0;
    while (bus.busy && n < 500) begin
      step();
      n++;
    end
    chk(nm, bus.busy, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=done");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 0;
    bus.in_data = 0;
    rsta = 1;
    repeat (3) @(posedge clka);
    #1;
    chk("rst_dataa", bus.dataa, 0);
    chk("rst_new", bus.new_dataa, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_level", bus.level, 0);
    chk("rst_busy", bus.busy, 0);
    @(negedge clka) rsta = 0;
    vt[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1};
    for (int i = 1; i < 5; i++) vt[i] = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 3'd0, 1'b1};
    for (int i = 5; i < 9; i++) vt[i] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 3'd0, 1'b1};
    for (int i = 9; i < 11; i++) vt[i] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 3'd0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      bus.in_valid = vt[i].v;
      bus.in_data = vt[i].d;
      step();
      chk($sformatf("v%0d_new", i), bus.new_dataa, vt[i].e_new);
      chk($sformatf("v%0d_dataa", i), bus.dataa, vt[i].e_dataa);
      chk($sformatf("v%0d_ready", i), bus.in_ready, vt[i].e_rdy);
      chk($sformatf("v%0d_level", i), bus.level, vt[i].e_lvl);
      chk($sformatf("v%0d_busy", i), bus.busy, vt[i].e_busy);
    end
    bus.in_valid = 0;
    rise_cyc.delete();
    rise_dat.delete();
    cyc = -1;
    for (int w = 0; w < 6; w++) begin
      bus.in_valid = 1;
      bus.in_data = 8'(w + 1);
      n = 0;
      do begin
        fire = bus.in_ready;
        step();
        n++;
      end while (!fire && n < 50);
      acc[w] = fire ? cyc : -1;
      chk($sformatf("full_acc%0d", w), acc[w], exp_acc[w]);
      if (w == 4) begin
        chk("full_ready", bus.in_ready, 0);
        chk("full_level", bus.level, 4);
      end
    end
    bus.in_valid = 0;
    drain("full_drain");
    chk("full_rises", rise_cyc.size(), 6);
    for (int k = 0; k < rise_cyc.size() && k < 6; k++) begin
      chk($sformatf("full_data%0d", k), rise_dat[k], 8'(k + 1));
      if (k == 0) chk("full_latency", rise_cyc[0], 1);
      else chk($sformatf("full_gap%0d", k), rise_cyc[k] - rise_cyc[k-1], H + L);
    end
    send(8'h11);
    send(8'h22);
    send(8'h33);
    chk("hold_new_pre", bus.new_dataa, 1);
    chk("hold_dataa_pre", bus.dataa, 8'h11);
    #3 rsta = 1;
    #1;
    chk("arst_new", bus.new_dataa, 0);
    chk("arst_level", bus.level, 0);
    chk("arst_dataa", bus.dataa, 0);
    chk("arst_ready", bus.in_ready, 1);
    chk("arst_busy", bus.busy, 0);
    @(negedge clka);
    @(negedge clka) rsta = 0;
    rise_dat.delete();
    repeat (20) step();
    chk("arst_no_emit", rise_dat.size(), 0);
    chk("arst_dataa_post", bus.dataa, 0);
    exp_q.delete();
    run_en = 1;
    sb_en = 1;
    seen_fall = 0;
    rcv = 0;
    sent = 0;
    n = 0;
    while (sent < 200 && n < 20000) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data = 8'(sent * 7 + 3);
      fire = bus.in_valid && bus.in_ready;
      step();
      if (fire) begin
        exp_q.push_back(bus.in_data);
        sent++;
      end
      n++;
    end
    bus.in_valid = 0;
    drain("rand_drain");
    chk("rand_sent", sent, 200);
    chk("rand_rcv", rcv, 200);
    chk("rand_left", exp_q.size(), 0);
    run_en = 0;
    sb_en = 0;
    b_got.delete();
    e2e_en = 1;
    for (int w = 0; w < 16; w++) send(8'(8'h10 + w));
    drain("e2e_drain");
    repeat (10) step();
    e2e_en = 0;
    chk("e2e_count", b_got.size(), 16);
    for (int k = 0; k < b_got.size() && k < 16; k++)
      chk($sformatf("e2e_data%0d", k), b_got[k], 8'(8'h10 + k));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
